// File: rtl/lsu_stage.sv
// Load/store unit between EX and MEM: issues data-memory requests, aligns and extends load data,
// and registers writeback fields. Optional misaligned-access trapping via LSU_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module lsu_stage #(
  parameter int XLEN    = 32,
  parameter int DADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic               flush_i,
  input  logic [6:0]         opcode_i,
  input  logic [2:0]         funct3_i,
  input  logic [XLEN-1:0]    alu_res_i,
  input  logic [XLEN-1:0]    store_data_i,
  input  logic [4:0]         rd_addr_i,
  input  logic               wreg_i,
  input  logic [11:0]        csr_waddr_i,
  input  logic               csr_wreg_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DADDR_W-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [XLEN-1:0]    dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [XLEN-1:0]    dmem_rdata_i,
  output logic               valid_o,
  output logic [4:0]         rd_addr_o,
  output logic               wreg_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic [11:0]        csr_waddr_o,
  output logic               csr_wreg_o,
  output logic [XLEN-1:0]    csr_wdata_o,
  output logic               misalign_o
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [1:0] SZ_B      = 2'b00;
  localparam logic [1:0] SZ_H      = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DRAIN} state_e;

  state_e               state_q;
  logic                 dmem_req_q, dmem_we_q;
  logic [DADDR_W-1:0]   dmem_addr_q;
  logic [3:0]           dmem_be_q;
  logic [XLEN-1:0]      dmem_wdata_q;
  logic                 valid_q, wreg_q, csr_wreg_q;
  logic [4:0]           rd_addr_q;
  logic [XLEN-1:0]      wdata_q, csr_wdata_q;
  logic [11:0]          csr_waddr_q;

  // Writeback fields of the access in flight, copied to the outputs on completion.
  logic [4:0]           p_rd_addr_q;
  logic                 p_wreg_q, p_csr_wreg_q;
  logic [11:0]          p_csr_waddr_q;
  logic [XLEN-1:0]      p_csr_wdata_q;
  logic [2:0]           p_funct3_q;
  logic [1:0]           p_off_q;

  logic                 is_load, is_store, f3_ok, mem_op, trap_d, mem_go, accept, valid_d;
  logic [DADDR_W-1:0]   eff_addr;
  logic [1:0]           lane_off_d;
  logic [3:0]           be_d;
  logic [XLEN-1:0]      wdata_d, load_data_d;
  logic [15:0]          lane_d;

  assign ex_ready_o = (state_q == S_IDLE);
  assign accept     = ex_valid_i & ex_ready_o & ~flush_i;
  assign eff_addr   = alu_res_i[DADDR_W-1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_load    = (opcode_i == OPC_LOAD);
    is_store   = (opcode_i == OPC_STORE);
    f3_ok      = 1'b0;
    lane_off_d = 2'b00;
    be_d       = 4'b1111;
    wdata_d    = store_data_i;
    if (is_load)
      f3_ok = (funct3_i[1:0] != 2'b11) && !(funct3_i[2] && funct3_i[1]);
    else if (is_store)
      f3_ok = !funct3_i[2] && (funct3_i[1:0] != 2'b11);
    mem_op = (is_load | is_store) & f3_ok;

    // Low address bits beyond the lane select are dropped, forcing the access aligned.
    case (funct3_i[1:0])
      SZ_B: begin
        lane_off_d = eff_addr[1:0];
        be_d       = 4'b0001 << lane_off_d;
        wdata_d    = {(XLEN/8){store_data_i[7:0]}};
      end
      SZ_H: begin
        lane_off_d = {eff_addr[1], 1'b0};
        be_d       = 4'b0011 << lane_off_d;
        wdata_d    = {(XLEN/16){store_data_i[15:0]}};
      end
      default: ;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    trap_d = mem_op && (((funct3_i[1:0] == SZ_H) && eff_addr[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00)));
`else
    trap_d = 1'b0;
`endif
    mem_go = mem_op & ~trap_d;

    valid_d = 1'b0;
    case (state_q)
      S_IDLE:   valid_d = accept & ~mem_go;
      S_REQ:    valid_d = dmem_gnt_i & dmem_we_q;
      S_WAIT_R: valid_d = dmem_rvalid_i & ~flush_i;
      default:  ;
    endcase
  end

  always_comb begin
    lane_d      = 16'(dmem_rdata_i >> {p_off_q, 3'b000});
    load_data_d = dmem_rdata_i;
    case (p_funct3_q[1:0])
      SZ_B:    load_data_d = {{(XLEN-8){lane_d[7] & ~p_funct3_q[2]}}, lane_d[7:0]};
      SZ_H:    load_data_d = {{(XLEN-16){lane_d[15] & ~p_funct3_q[2]}}, lane_d};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_be_q     <= '0;
      dmem_wdata_q  <= '0;
      valid_q       <= 1'b0;
      rd_addr_q     <= '0;
      wreg_q        <= 1'b0;
      wdata_q       <= '0;
      csr_waddr_q   <= '0;
      csr_wreg_q    <= 1'b0;
      csr_wdata_q   <= '0;
      p_rd_addr_q   <= '0;
      p_wreg_q      <= 1'b0;
      p_csr_waddr_q <= '0;
      p_csr_wreg_q  <= 1'b0;
      p_csr_wdata_q <= '0;
      p_funct3_q    <= '0;
      p_off_q       <= '0;
    end else begin
      valid_q <= valid_d;
      case (state_q)
        S_IDLE: begin
          if (accept && mem_go) begin
            state_q       <= S_REQ;
            dmem_req_q    <= 1'b1;
            dmem_we_q     <= is_store;
            dmem_addr_q   <= {eff_addr[DADDR_W-1:2], 2'b00};
            dmem_be_q     <= be_d;
            dmem_wdata_q  <= wdata_d;
            p_rd_addr_q   <= rd_addr_i;
            p_wreg_q      <= wreg_i;
            p_csr_waddr_q <= csr_waddr_i;
            p_csr_wreg_q  <= csr_wreg_i;
            p_csr_wdata_q <= csr_wdata_i;
            p_funct3_q    <= funct3_i;
            p_off_q       <= lane_off_d;
          end else if (accept) begin
            // Pass-through, reserved-funct3 memory op, or trapped misaligned access.
            rd_addr_q   <= rd_addr_i;
            wreg_q      <= wreg_i & ~(is_load | is_store);
            wdata_q     <= alu_res_i;
            csr_waddr_q <= csr_waddr_i;
            csr_wreg_q  <= csr_wreg_i & ~trap_d;
            csr_wdata_q <= csr_wdata_i;
          end
        end
        S_REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            if (dmem_we_q) begin
              state_q     <= S_IDLE;
              rd_addr_q   <= p_rd_addr_q;
              wreg_q      <= 1'b0;
              csr_waddr_q <= p_csr_waddr_q;
              csr_wreg_q  <= p_csr_wreg_q;
              csr_wdata_q <= p_csr_wdata_q;
            end else begin
              state_q <= flush_i ? S_DRAIN : S_WAIT_R;
            end
          end else if (flush_i) begin
            dmem_req_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_WAIT_R: begin
          if (dmem_rvalid_i) begin
            state_q <= S_IDLE;
            if (!flush_i) begin
              rd_addr_q   <= p_rd_addr_q;
              wreg_q      <= p_wreg_q;
              wdata_q     <= load_data_d;
              csr_waddr_q <= p_csr_waddr_q;
              csr_wreg_q  <= p_csr_wreg_q;
              csr_wdata_q <= p_csr_wdata_q;
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dmem_rvalid_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  // Only a trapped access completes straight from IDLE with the fault set; any other completion clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       misalign_q <= 1'b0;
    else if (valid_d) misalign_q <= (state_q == S_IDLE) & trap_d;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_be_o    = dmem_be_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign valid_o      = valid_q;
  assign rd_addr_o    = rd_addr_q;
  assign wreg_o       = wreg_q;
  assign wdata_o      = wdata_q;
  assign csr_waddr_o  = csr_waddr_q;
  assign csr_wreg_o   = csr_wreg_q;
  assign csr_wdata_o  = csr_wdata_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed cases plus random traffic against a byte-level
// memory model, with a scoreboard queue drained by a monitor on every valid_o.
`timescale 1ns/1ps
module tb_lsu_stage;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  logic        clk, rst_n;
  logic        ex_valid_i, ex_ready_o, flush_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_res_i, store_data_i, csr_wdata_i;
  logic [4:0]  rd_addr_i;
  logic        wreg_i, csr_wreg_i;
  logic [11:0] csr_waddr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o, wreg_o, csr_wreg_o, misalign_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wdata_o, csr_wdata_o;
  logic [11:0] csr_waddr_o;

  lsu_stage #(.XLEN(32), .DADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .flush_i(flush_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .alu_res_i(alu_res_i),
    .store_data_i(store_data_i), .rd_addr_i(rd_addr_i), .wreg_i(wreg_i),
    .csr_waddr_i(csr_waddr_i), .csr_wreg_i(csr_wreg_i), .csr_wdata_i(csr_wdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .csr_waddr_o(csr_waddr_o),
    .csr_wreg_o(csr_wreg_o), .csr_wdata_o(csr_wdata_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [11:0] csr_a;
    logic        csr_w;
    logic [31:0] csr_d;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  mem_b [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    opcode_i     = 7'($urandom);
    funct3_i     = 3'($urandom);
    alu_res_i    = $urandom;
    store_data_i = $urandom;
    rd_addr_i    = 5'($urandom);
    wreg_i       = 1'($urandom);
    csr_waddr_i  = 12'($urandom);
    csr_wreg_i   = 1'($urandom);
    csr_wdata_i  = $urandom;
  endtask

  function automatic logic [5:0] idx(input logic [31:0] a);
    return a[5:0];
  endfunction

  function automatic logic [31:0] bus_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return {mem_b[idx(wa + 3)], mem_b[idx(wa + 2)], mem_b[idx(wa + 1)], mem_b[idx(wa)]};
  endfunction

  // Reference load: gather n bytes little-endian from the aligned address, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] base, input int n, input logic uns);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_b[idx(base + i)]) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", valid_o, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("valid_cycle", cyc, mon_e.cyc);
        check("rd_addr_o", rd_addr_o, mon_e.rd);
        check("wreg_o", wreg_o, mon_e.wreg);
        if (mon_e.chk_wdata) check("wdata_o", wdata_o, mon_e.wdata);
        check("csr_waddr_o", csr_waddr_o, mon_e.csr_a);
        check("csr_wreg_o", csr_wreg_o, mon_e.csr_w);
        check("csr_wdata_o", csr_wdata_o, mon_e.csr_d);
        check("misalign_o", misalign_o, mon_e.mis);
      end
    end
  end

  // fl: 0 none, 1 flush in REQ without gnt, 2 flush with gnt, 3 flush in WAIT_R, 4 flush with rvalid.
  task automatic run_txn(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input int g,
                         input int r, input int fl);
    logic is_ld, is_st, f3ok, trap;
    int n;
    logic [31:0] base, exp_wd;
    logic [3:0] exp_be;
    exp_t e;
    is_ld = (opc == LOAD);
    is_st = (opc == STORE);
    f3ok  = is_ld ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                  : (f3 inside {3'b000, 3'b001, 3'b010});
    n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap  = (is_ld || is_st) && f3ok && (addr % n != 0);
`endif
    base  = addr - (addr % n);

    check("ex_ready_before_issue", ex_ready_o, 1);
    ex_valid_i = 1; opcode_i = opc; funct3_i = f3; alu_res_i = addr; store_data_i = sdata;
    rd_addr_i = rd; wreg_i = 1'($urandom); csr_waddr_i = 12'($urandom);
    csr_wreg_i = 1'($urandom); csr_wdata_i = $urandom;
    e.rd = rd; e.wreg = wreg_i; e.wdata = addr; e.chk_wdata = 1;
    e.csr_a = csr_waddr_i; e.csr_w = csr_wreg_i; e.csr_d = csr_wdata_i; e.mis = 0;

    if (!((is_ld || is_st) && f3ok) || trap) begin
      if (is_ld || is_st) e.wreg = 0;
      if (trap) begin e.csr_w = 0; e.mis = 1; end
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      tick();
      ex_valid_i = 0; scramble();
      check("no_req_passthru", dmem_req_o, 0);
      return;
    end

    tick();
    ex_valid_i = 0; scramble();
    check("req_first", dmem_req_o, 1);
    check("we", dmem_we_o, is_st);
    check("addr", dmem_addr_o, {addr[31:2], 2'b00});
    if (is_st) begin
      exp_be = 0; exp_wd = 0;
      for (int i = 0; i < 4; i++) begin
        if (i >= int'(base[1:0]) && i < int'(base[1:0]) + n) exp_be[i] = 1'b1;
        exp_wd[8 * i +: 8] = sdata[8 * (i % n) +: 8];
      end
      check("be", dmem_be_o, exp_be);
      check("store_wdata", dmem_wdata_o, exp_wd);
    end
    repeat (g) begin
      tick();
      check("req_held", dmem_req_o, 1);
      check("addr_held", dmem_addr_o, {addr[31:2], 2'b00});
    end

    if (fl == 1) begin
      flush_i = 1; tick(); flush_i = 0;
      check("flush_req_ready", ex_ready_o, 1);
      check("flush_req_noreq", dmem_req_o, 0);
      return;
    end

    dmem_gnt_i = 1; flush_i = (fl == 2);
    if (is_st) begin
      for (int i = 0; i < n; i++) mem_b[idx(base + i)] = sdata[8 * i +: 8];
      e.wreg = 0; e.chk_wdata = 0; e.cyc = cyc + 1;
      exp_q.push_back(e);
      tick();
      dmem_gnt_i = 0; flush_i = 0;
      check("store_done_ready", ex_ready_o, 1);
      check("store_req_dropped", dmem_req_o, 0);
      return;
    end
    tick();
    dmem_gnt_i = 0; flush_i = 0;
    check("load_req_dropped", dmem_req_o, 0);

    if (fl == 3) begin
      check("busy_wait_r", ex_ready_o, 0);
      flush_i = 1; tick(); flush_i = 0;
    end
    check("busy_before_rvalid", ex_ready_o, 0);
    repeat (r) begin
      tick();
      check("busy_waiting", ex_ready_o, 0);
    end
    dmem_rvalid_i = 1; dmem_rdata_i = bus_word(addr);
    if (fl == 4) flush_i = 1;
    if (fl == 0) begin
      e.wdata = model_load(base, n, f3[2]);
      e.cyc   = cyc + 1;
      exp_q.push_back(e);
    end
    tick();
    dmem_rvalid_i = 0; flush_i = 0; dmem_rdata_i = $urandom;
    check("load_done_ready", ex_ready_o, 1);
  endtask

  initial begin
    rst_n = 0; ex_valid_i = 0; flush_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
    dmem_rdata_i = 0; scramble();
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", dmem_req_o, 0);
    check("rst_dmem", {dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o}, 0);
    check("rst_valid", valid_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_wb", {rd_addr_o, wreg_o, wdata_o[15:0], csr_waddr_o, csr_wreg_o}, 0);
    check("rst_wb_data", {wdata_o, csr_wdata_o}, 0);
    @(negedge clk) rst_n = 1;
    tick();
    check("ready_after_reset", ex_ready_o, 1);

    run_txn(ALU, 3'b000, 32'h1234, 0, 5'd5, 0, 0, 0);
    mem_b[0] = 8'h00; mem_b[1] = 8'h00; mem_b[2] = 8'hFF; mem_b[3] = 8'h80;
    run_txn(LOAD, 3'b000, 32'h103, 0, 5'd7, 0, 0, 0);
    run_txn(LOAD, 3'b100, 32'h103, 0, 5'd8, 0, 0, 0);
    run_txn(STORE, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9, 3, 0, 0);
    run_txn(LOAD, 3'b010, 32'h120, 0, 5'd10, 0, 2, 3);
    run_txn(LOAD, 3'b010, 32'h101, 0, 5'd11, 1, 1, 0);
    run_txn(LOAD, 3'b110, 32'h104, 0, 5'd12, 0, 0, 0);

    // Accept blocked by a same-cycle flush.
    ex_valid_i = 1; flush_i = 1; opcode_i = LOAD; funct3_i = 3'b010; alu_res_i = 32'h108;
    tick();
    ex_valid_i = 0; flush_i = 0;
    check("flush_blocks_accept", dmem_req_o, 0);

    // Reset while a load is in REQ, then a stray rvalid.
    ex_valid_i = 1; opcode_i = LOAD; funct3_i = 3'b010; alu_res_i = 32'h110;
    tick();
    ex_valid_i = 0;
    check("req_before_reset", dmem_req_o, 1);
    #2 rst_n = 0;
    #1;
    check("midrst_req", dmem_req_o, 0);
    check("midrst_dmem", {dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o}, 0);
    check("midrst_wb", {valid_o, misalign_o, rd_addr_o, wreg_o, csr_waddr_o, csr_wreg_o}, 0);
    check("midrst_wb_data", {wdata_o, csr_wdata_o}, 0);
    @(negedge clk) rst_n = 1;
    tick();
    dmem_rvalid_i = 1; dmem_rdata_i = $urandom;
    tick();
    dmem_rvalid_i = 0;
    check("ready_after_midrst", ex_ready_o, 1);

    for (int t = 0; t < 200; t++) begin
      int kind, fl;
      logic [6:0] opc;
      if ($urandom_range(0, 3) == 0) begin
        dmem_gnt_i = 1'($urandom); dmem_rvalid_i = 1; dmem_rdata_i = $urandom;
        tick();
        dmem_gnt_i = 0; dmem_rvalid_i = 0;
      end
      kind = $urandom_range(0, 9);
      opc  = (kind < 3) ? ALU : (kind < 7) ? LOAD : STORE;
      fl   = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, (opc == LOAD) ? 4 : 2);
      run_txn(opc, 3'($urandom), 32'h100 + $urandom_range(0, 63), $urandom, 5'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), fl);
    end

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
